// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: encodes instruction descriptions into RV32I words and loads them into instruction memory
// Holds the core in reset (cpu_hold) until a complete program has been written.
module instr_encoder_loader #(
    parameter int ADDR_W    = 8,
    parameter int MAX_WORDS = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_kind,
    input  logic [2:0]        in_aluop,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [20:0]       in_imm,
    input  logic              in_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [ADDR_W:0]   word_count,
    output logic              cpu_hold,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ACCEPT = 3'd1;
    localparam logic [2:0] S_WRITE  = 3'd2;
    localparam logic [2:0] S_DONE   = 3'd3;
    localparam logic [2:0] S_ERROR  = 3'd4;
    localparam logic [ADDR_W:0] MAX = (ADDR_W+1)'(MAX_WORDS);

    logic [2:0]        state;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W:0]   count;
    logic [31:0]       word;
    logic              last_q;
    logic [1:0]        code;
    logic [31:0]       enc;
    logic              is_sub, bad_op, imm12_ok, imm13_ok, illegal, range_bad;
    logic [2:0]        f3;
    logic [ADDR_W:0]   count_next;

    always_comb begin
        is_sub    = in_aluop == 3'b001;
        f3        = is_sub ? 3'b000 : in_aluop;
        bad_op    = in_aluop == 3'b011 || in_aluop == 3'b100 || in_aluop == 3'b101;
        imm12_ok  = &in_imm[20:11] || ~|in_imm[20:11];
        imm13_ok  = (&in_imm[20:12] || ~|in_imm[20:12]) && !in_imm[0];
        illegal   = (in_kind[2] && in_kind[1]) ||
                    ((in_kind == 3'd2 || in_kind == 3'd3) && bad_op) ||
                    (in_kind == 3'd3 && is_sub);
        range_bad = ((in_kind == 3'd0 || in_kind == 3'd1 || in_kind == 3'd3) && !imm12_ok) ||
                    (in_kind == 3'd4 && !imm13_ok) ||
                    (in_kind == 3'd5 && in_imm[0]);
        enc = in_kind == 3'd0 ? {in_imm[11:0], in_rs1, 3'b010, in_rd, 7'b0000011} :
              in_kind == 3'd1 ? {in_imm[11:5], in_rs2, in_rs1, 3'b010, in_imm[4:0], 7'b0100011} :
              in_kind == 3'd2 ? {is_sub ? 7'b0100000 : 7'b0, in_rs2, in_rs1, f3, in_rd, 7'b0110011} :
              in_kind == 3'd3 ? {in_imm[11:0], in_rs1, f3, in_rd, 7'b0010011} :
              in_kind == 3'd4 ? {in_imm[12], in_imm[10:5], in_rs2, in_rs1, 3'b000, in_imm[4:1], in_imm[11], 7'b1100011} :
                                {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, 7'b1101111};
        count_next = count + (ADDR_W+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            addr   <= '0;
            count  <= '0;
            word   <= '0;
            last_q <= 1'b0;
            code   <= 2'd0;
        end else begin
            case (state)
                S_ACCEPT: if (in_valid) begin
                    word   <= enc;
                    last_q <= in_last;
                    state  <= (illegal || range_bad) ? S_ERROR : S_WRITE;
                    code   <= illegal ? 2'd1 : range_bad ? 2'd2 : 2'd0;
                end
                S_WRITE: begin
                    addr  <= addr + ADDR_W'(1);
                    count <= count_next;
                    state <= last_q ? S_DONE : (count_next == MAX) ? S_ERROR : S_ACCEPT;
                    code  <= (!last_q && count_next == MAX) ? 2'd3 : 2'd0;
                end
                default: if (start) begin
                    state <= S_ACCEPT;
                    addr  <= '0;
                    count <= '0;
                    code  <= 2'd0;
                end
            endcase
        end
    end

    assign in_ready   = state == S_ACCEPT;
    assign mem_we     = state == S_WRITE;
    assign mem_addr   = addr;
    assign mem_wdata  = word;
    assign word_count = count;
    assign cpu_hold   = state != S_DONE;
    assign done       = state == S_DONE;
    assign err        = state == S_ERROR;
    assign err_code   = code;
endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb_instr_encoder_loader: scoreboard bench for the instruction encoder/loader
// Expected writes are queued at handshake time and matched against mem_we strobes.
module tb_instr_encoder_loader;
    logic        clk = 1'b0;
    logic        reset, start, in_valid, in_ready, in_last;
    logic [2:0]  in_kind, in_aluop;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [20:0] in_imm;
    logic        mem_we, cpu_hold, done, err;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [8:0]  word_count;
    logic [1:0]  err_code;

    int          vectors = 0;
    int          miscompares = 0;
    logic [39:0] sb[$];
    logic [39:0] e;
    logic [7:0]  exp_addr;

    instr_encoder_loader #(.ADDR_W(8), .MAX_WORDS(4)) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_kind(in_kind), .in_aluop(in_aluop), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_imm(in_imm), .in_last(in_last), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .word_count(word_count), .cpu_hold(cpu_hold), .done(done),
        .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            if (sb.size() == 0) chk("spurious_we", 1, 0);
            else begin
                e = sb.pop_front();
                chk("wr_addr", 64'(mem_addr), 64'(e[39:32]));
                chk("wr_data", 64'(mem_wdata), 64'(e[31:0]));
            end
        end
    end

    task automatic do_start;
        @(negedge clk);
        start = 1'b1;
        exp_addr = 8'd0;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic drive(input logic [2:0] k, input logic [2:0] op, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [20:0] imm,
                         input logic last);
        in_kind = k; in_aluop = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_imm = imm; in_last = last; in_valid = 1'b1;
    endtask

    task automatic send(input logic [2:0] k, input logic [2:0] op, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [20:0] imm,
                        input logic last, input logic [31:0] w, input logic legal);
        int n = 0;
        @(negedge clk);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        drive(k, op, rd, rs1, rs2, imm, last);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("handshake_timeout", 0, 1);
            in_valid = 1'b0;
        end else begin
            if (legal) begin
                sb.push_back({exp_addr, w});
                exp_addr++;
            end
            @(posedge clk);
            #1 in_valid = 1'b0;
        end
    endtask

    task automatic settle;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        in_kind = '0; in_aluop = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
        exp_addr = 8'd0;
        repeat (2) @(negedge clk);
        chk("rst_hold", 64'(cpu_hold), 1);
        chk("rst_we", 64'(mem_we), 0);
        chk("rst_ready", 64'(in_ready), 0);
        chk("rst_flags", {62'd0, done, err}, 0);
        chk("rst_addr", 64'(mem_addr), 0);
        chk("rst_count", 64'(word_count), 0);
        chk("rst_code", 64'(err_code), 0);
        reset = 1'b0;

        do_start;
        chk("start_hold", 64'(cpu_hold), 1);
        send(3'd3, 3'b000, 5'd1, 5'd0, 5'd0, 21'd5, 1'b1, 32'h00500093, 1'b1);
        settle;
        chk("addi_done", 64'(done), 1);
        chk("addi_hold", 64'(cpu_hold), 0);
        chk("addi_count", 64'(word_count), 1);

        do_start;
        chk("restart_hold", 64'(cpu_hold), 1);
        chk("restart_done", 64'(done), 0);
        send(3'd2, 3'b000, 5'd3, 5'd1, 5'd2, 21'd0, 1'b0, 32'h002081B3, 1'b1);
        send(3'd2, 3'b001, 5'd3, 5'd1, 5'd2, 21'd0, 1'b1, 32'h402081B3, 1'b1);
        settle;
        chk("r_count", 64'(word_count), 2);
        chk("r_done", 64'(done), 1);

        do_start;
        send(3'd0, 3'b000, 5'd2, 5'd1, 5'd0, 21'd0, 1'b0, 32'h0000A103, 1'b1);
        send(3'd1, 3'b000, 5'd0, 5'd0, 5'd2, 21'd8, 1'b0, 32'h00202423, 1'b1);
        send(3'd4, 3'b000, 5'd0, 5'd1, 5'd2, 21'h1FFFFC, 1'b0, 32'hFE208EE3, 1'b1);
        send(3'd5, 3'b000, 5'd1, 5'd0, 5'd0, 21'd8, 1'b1, 32'h008000EF, 1'b1);
        settle;
        chk("mix_count", 64'(word_count), 4);
        chk("mix_done", 64'(done), 1);

        do_start;
        send(3'd4, 3'b000, 5'd0, 5'd1, 5'd2, 21'd3, 1'b1, 32'h0, 1'b0);
        settle;
        chk("beq_odd_err", 64'(err), 1);
        chk("beq_odd_code", 64'(err_code), 2);
        chk("beq_odd_hold", 64'(cpu_hold), 1);
        chk("beq_odd_count", 64'(word_count), 0);

        do_start;
        send(3'd3, 3'b001, 5'd1, 5'd1, 5'd0, 21'd1, 1'b1, 32'h0, 1'b0);
        settle;
        chk("isub_code", 64'(err_code), 1);

        do_start;
        send(3'd0, 3'b000, 5'd1, 5'd1, 5'd0, 21'd2048, 1'b1, 32'h0, 1'b0);
        settle;
        chk("lw_range_code", 64'(err_code), 2);

        do_start;
        send(3'd6, 3'b000, 5'd1, 5'd1, 5'd0, 21'd0, 1'b1, 32'h0, 1'b0);
        settle;
        chk("kind6_code", 64'(err_code), 1);

        do_start;
        chk("recover_err", 64'(err), 0);
        send(3'd0, 3'b000, 5'd2, 5'd1, 5'd0, 21'h1FF800, 1'b1, 32'h8000A103, 1'b1);
        settle;
        chk("recover_done", 64'(done), 1);

        do_start;
        for (int i = 1; i <= 4; i++)
            send(3'd3, 3'b000, 5'(i), 5'd0, 5'd0, 21'(i), 1'b0,
                 {12'(i), 5'd0, 3'b000, 5'(i), 7'b0010011}, 1'b1);
        settle;
        chk("ovf_err", 64'(err), 1);
        chk("ovf_code", 64'(err_code), 3);
        chk("ovf_ready", 64'(in_ready), 0);
        chk("ovf_count", 64'(word_count), 4);
        @(negedge clk);
        drive(3'd3, 3'b000, 5'd5, 5'd0, 5'd0, 21'd5, 1'b0);
        repeat (4) @(negedge clk);
        in_valid = 1'b0;
        chk("ovf_stuck", 64'(word_count), 4);

        do_start;
        send(3'd3, 3'b000, 5'd1, 5'd0, 5'd0, 21'd5, 1'b0, 32'h00500093, 1'b1);
        @(negedge clk);
        drive(3'd2, 3'b000, 5'd3, 5'd1, 5'd2, 21'd0, 1'b1);
        for (int n = 0; n < 50 && !in_ready; n++) @(negedge clk);
        chk("mid_ready", 64'(in_ready), 1);
        sb.push_back({8'd1, 32'h002081B3});
        @(posedge clk);
        #1 in_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("mid_rst_we", 64'(mem_we), 0);
        chk("mid_rst_count", 64'(word_count), 0);
        chk("mid_rst_hold", 64'(cpu_hold), 1);
        chk("mid_rst_ready", 64'(in_ready), 0);
        reset = 1'b0;
        settle;
        chk("sb_empty", 64'(sb.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
